// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, coordinate decode for the text-mode card, and a registered
// RGB332 + sync output stage sharing one pixel period of latency.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] color_in,
  output logic [9:0] x_ptr,
  output logic [9:0] y_ptr,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT_C   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C  = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             pix_tick;
  logic             h_vis;
  logic             v_vis;
  logic             visible;
  logic             hs_raw;
  logic             vs_raw;

  // Pixel tick on the last system clock of each pixel period.
  always_comb begin
    pix_tick = (div_cnt == DIV_LAST);
  end

  // Combinational decode of the counter registers; stable across a pixel.
  always_comb begin
    h_vis   = (h_cnt < H_ACT_C);
    v_vis   = (v_cnt < V_ACT_C);
    visible = h_vis & v_vis;
    x_ptr   = h_vis ? h_cnt : '0;
    y_ptr   = v_vis ? v_cnt : '0;
    hs_raw  = !((h_cnt >= H_SS_C) && (h_cnt < H_SE_C));
    vs_raw  = !((v_cnt >= V_SS_C) && (v_cnt < V_SE_C));
  end

  // Clock divider producing the pixel rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters: column advances per pixel, row advances on column wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST_C) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Output stage: sync and colour registered together so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_tick) begin
      hsync <= hs_raw;
      vsync <= vs_raw;
      {red, green, blue} <= visible ? color_in : '0;
    end
  end

  // One-clock pulse as the counters wrap back to the frame origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h_cnt == H_LAST_C) && (v_cnt == V_LAST_C);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (CLK_DIV=2 and CLK_DIV=1) with a
// shortened vertical frame, checked every clock against a closed-form model
// through a scoreboard, plus measured sync widths and periods.
module tb_vga_timing_gen;

  localparam int unsigned HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       fs;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] color_in = 8'h00;

  logic [9:0] x0, y0, x1, y1;
  logic       hs0, vs0, fs0, hs1, vs1, fs1;
  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  vga_timing_gen #(.CLK_DIV(2), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut0 (
    .clk(clk), .reset(reset), .color_in(color_in), .x_ptr(x0), .y_ptr(y0),
    .hsync(hs0), .vsync(vs0), .red(r0), .green(g0), .blue(b0), .frame_start(fs0));

  vga_timing_gen #(.CLK_DIV(1), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clk(clk), .reset(reset), .color_in(color_in), .x_ptr(x1), .y_ptr(y1),
    .hsync(hs1), .vsync(vs1), .red(r1), .green(g1), .blue(b1), .frame_start(fs1));

  always #5 clk = ~clk;

  // Model and measurement state, index 0 -> dut0, index 1 -> dut1.
  int unsigned divs [2] = '{2, 1};
  int unsigned k [2];
  logic [7:0]  lc [2];
  outs_t       q0 [$];
  outs_t       q1 [$];
  int unsigned hlow [2], vlow [2];
  int unsigned last_hfall [2], last_vfall [2], last_fs [2];
  bit          hseen [2], vseen [2], fseen [2];
  logic        prev_hs [2], prev_vs [2];
  int unsigned cyc = 0;

  localparam outs_t RST_OUT = '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, r: '0, g: '0, b: '0, fs: 1'b0};

  function automatic outs_t model(int unsigned d, int unsigned kk, logic [7:0] c);
    outs_t o;
    int unsigned p, h, v, ph, pv;
    p = kk / d;
    h = p % HT;
    v = (p / HT) % VT;
    o.x = (h < HA) ? 10'(h) : 10'd0;
    o.y = (v < VA) ? 10'(v) : 10'd0;
    if (p == 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      {o.r, o.g, o.b} = 8'h00;
    end else begin
      ph = (p - 1) % HT;
      pv = ((p - 1) / HT) % VT;
      o.hs = !((ph >= HA + HF) && (ph < HA + HF + HS));
      o.vs = !((pv >= VA + VF) && (pv < VA + VF + VS));
      {o.r, o.g, o.b} = ((ph < HA) && (pv < VA)) ? c : 8'h00;
    end
    o.fs = (kk > 0) && (kk % d == 0) && (p % (HT * VT) == 0);
    return o;
  endfunction

  function automatic outs_t actual(int i);
    if (i == 0) return '{x: x0, y: y0, hs: hs0, vs: vs0, r: r0, g: g0, b: b0, fs: fs0};
    return '{x: x1, y: y1, hs: hs1, vs: vs1, r: r1, g: g1, b: b1, fs: fs1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_meas();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; lc[i] = 8'h00;
      hlow[i] = 0; vlow[i] = 0;
      hseen[i] = 0; vseen[i] = 0; fseen[i] = 0;
      prev_hs[i] = 1'b1; prev_vs[i] = 1'b1;
    end
  endtask

  // One clock: model advances and pushes at the edge, outputs compared at negedge.
  task automatic step();
    outs_t o, e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        k[i]++;
        if (k[i] % divs[i] == 0) lc[i] = color_in;
      end
    end
    q0.push_back(model(divs[0], k[0], lc[0]));
    q1.push_back(model(divs[1], k[1], lc[1]));
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      o = actual(i);
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk((i == 0) ? "outs_div2" : "outs_div1", 64'(o), 64'(e));
      if (!o.hs) hlow[i]++;
      else if (hlow[i] != 0) begin
        chk("hsync_low_clks", 64'(hlow[i]), 64'(HS * divs[i]));
        hlow[i] = 0;
      end
      if (prev_hs[i] && !o.hs) begin
        if (hseen[i]) chk("line_period", 64'(cyc - last_hfall[i]), 64'(HT * divs[i]));
        last_hfall[i] = cyc; hseen[i] = 1;
      end
      prev_hs[i] = o.hs;
      if (!o.vs) vlow[i]++;
      else if (vlow[i] != 0) begin
        chk("vsync_low_clks", 64'(vlow[i]), 64'(VS * HT * divs[i]));
        vlow[i] = 0;
      end
      if (prev_vs[i] && !o.vs) begin
        if (vseen[i]) chk("vsync_period", 64'(cyc - last_vfall[i]), 64'(HT * VT * divs[i]));
        last_vfall[i] = cyc; vseen[i] = 1;
      end
      prev_vs[i] = o.vs;
      if (o.fs) begin
        if (fseen[i]) chk("frame_period", 64'(cyc - last_fs[i]), 64'(HT * VT * divs[i]));
        last_fs[i] = cyc; fseen[i] = 1;
      end
    end
  endtask

  initial begin
    clear_meas();
    // Power-on reset held for a few clocks.
    repeat (3) step();
    reset = 1'b0;

    // Run into the middle of a line with random colours.
    for (int n = 0; n < 2600; n++) begin
      color_in = 8'($urandom);
      step();
    end

    // Asynchronous reset between clock edges: outputs return at once.
    #3 reset = 1'b1;
    #1;
    chk("async_rst_div2", 64'(actual(0)), 64'(RST_OUT));
    chk("async_rst_div1", 64'(actual(1)), 64'(RST_OUT));
    clear_meas();
    q0.delete();
    q1.delete();
    step();
    reset = 1'b0;

    // Two full frames of the slower instance: random, then solid white, then 0xA5.
    for (int n = 0; n < 2 * HT * VT * 2 + 200; n++) begin
      if (n < 15000) color_in = 8'($urandom);
      else if (n < 28000) color_in = 8'hFF;
      else color_in = 8'hA5;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
